// File: rtl/watchdog_timer.sv
// watchdog_timer
//
// Single-clock watchdog. Software enables the block (WDEN), programs a
// timeout count (WTOCNT) and periodically kicks it (WDLIVE). If no kick
// arrives before the count expires, the block raises a level interrupt.
// The interrupt stays high until the watchdog is kicked or disabled.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset (0 = reset)
//   wr_en          register write strobe
//   wr_addr[1:0]   0 = WDEN, 1 = WDLIVE (kick), 2 = WTOCNT, 3 = ignored
//   wr_data[31:0]  write data. WDEN/WDLIVE use bit 0. WTOCNT uses [CNT_W-1:0].
//   WDT_interrupt  registered level timeout interrupt
//   cnt_out        current timeout count
//   wdt_state      FSM state: 00 = IDLE, 01 = COUNT, 10 = TIMEOUT
//
// Write port handshake: wr_en is a valid-only strobe with no ready.
// Every cycle with wr_en = 1 is exactly one write, and that write is
// captured at the next rising edge. Back-pressure is never applied.
//
// CNT_W must be in the range 1..32, because WTOCNT is taken from wr_data.

module watchdog_timer #(
  parameter int CNT_W    = 32,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [31:0]      wr_data,
  output logic             WDT_interrupt,
  output logic [CNT_W-1:0] cnt_out,
  output logic [1:0]       wdt_state
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_COUNT   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [PW-1:0]    presc_q,  presc_d;
  logic             irq_q,    irq_d;
  logic             wden_q,   wden_d;
  logic [CNT_W-1:0] wtocnt_q, wtocnt_d;

  logic wr_wden;
  logic wr_wtocnt;
  logic kick;
  logic disable_now;
  logic tick;

  // Only the low bits of wr_data are architected.
  logic wr_data_unused;
  assign wr_data_unused = ^wr_data;

  always_comb begin
    wr_wden   = wr_en && (wr_addr == 2'd0);
    wr_wtocnt = wr_en && (wr_addr == 2'd2);
    kick      = wr_en && (wr_addr == 2'd1) && wr_data[0];

    wden_d   = wr_wden   ? wr_data[0]         : wden_q;
    wtocnt_d = wr_wtocnt ? wr_data[CNT_W-1:0] : wtocnt_q;

    // A WDEN = 0 write takes effect at its own capturing edge, so a
    // disable clears the interrupt in one edge, the same as a kick.
    disable_now = !wden_d;
    tick        = (presc_q == PRESC_LAST);

    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    irq_d   = irq_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        presc_d = '0;
        irq_d   = 1'b0;
        // Enabling uses the stored register. The state changes one edge
        // after WDEN is captured. A kick here is ignored.
        if (wden_q && !disable_now) begin
          state_d = ST_COUNT;
        end
      end

      ST_COUNT: begin
        if (disable_now) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          presc_d = '0;
        end else if (kick) begin
          cnt_d   = '0;
          presc_d = '0;
        end else if (tick) begin
          presc_d = '0;
          // The compare is >= against the stored WTOCNT. Shrinking WTOCNT
          // below cnt therefore times out at the next tick and never wraps.
          if (cnt_q >= wtocnt_q) begin
            state_d = ST_TIMEOUT;
            irq_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      ST_TIMEOUT: begin
        if (disable_now) begin
          state_d = ST_IDLE;
          irq_d   = 1'b0;
          cnt_d   = '0;
          presc_d = '0;
        end else if (kick) begin
          state_d = ST_COUNT;
          irq_d   = 1'b0;
          cnt_d   = '0;
          presc_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        presc_d = '0;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      presc_q  <= '0;
      irq_q    <= 1'b0;
      wden_q   <= 1'b0;
      wtocnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      presc_q  <= presc_d;
      irq_q    <= irq_d;
      wden_q   <= wden_d;
      wtocnt_q <= wtocnt_d;
    end
  end

  assign WDT_interrupt = irq_q;
  assign cnt_out       = cnt_q;
  assign wdt_state     = state_q;

endmodule

// File: tb/tb_watchdog_timer.sv
// Directed testbench for watchdog_timer.
// u1 uses PRESCALE = 1 and u4 uses PRESCALE = 4. Both share all inputs.
// Every expected value below is worked out by hand from the timing rules.

module tb_watchdog_timer;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;

  logic        irq1, irq4;
  logic [31:0] cnt1, cnt4;
  logic [1:0]  st1,  st4;

  int n_tests = 0;
  int n_fail  = 0;

  watchdog_timer #(.CNT_W(32), .PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .WDT_interrupt(irq1), .cnt_out(cnt1), .wdt_state(st1)
  );

  watchdog_timer #(.CNT_W(32), .PRESCALE(4)) u4 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .WDT_interrupt(irq4), .cnt_out(cnt4), .wdt_state(st4)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks. Inputs change 1 time unit after a rising edge, and
  // outputs are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    step();
    wr_en   = 1'b0;
    wr_addr = 2'd3;
    wr_data = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 2'd3;
    wr_data = '0;

    // Reset state
    step();
    check("rst_irq",   {31'd0, irq1}, 32'd0);
    check("rst_cnt",   cnt1,          32'd0);
    check("rst_state", {30'd0, st1},  32'd0);
    step();
    rst = 1'b1;
    step();
    check("idle_after_rst", {30'd0, st1}, 32'd0);

    // Basic timeout: WTOCNT = 5, WDEN captured at E0
    wr(2'd2, 32'd5);
    wr(2'd0, 32'd1);
    check("e0_still_idle", {30'd0, st1}, 32'd0);
    step();
    check("e1_state", {30'd0, st1}, 32'd1);
    check("e1_cnt",   cnt1,         32'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("count_cnt", cnt1,          32'(k));
      check("count_irq", {31'd0, irq1}, 32'd0);
    end
    step();
    check("e7_irq",   {31'd0, irq1}, 32'd1);
    check("e7_state", {30'd0, st1},  32'd2);
    check("e7_cnt",   cnt1,          32'd5);
    for (int k = 0; k < 10; k++) begin
      step();
      check("timeout_hold_irq", {31'd0, irq1}, 32'd1);
    end
    check("timeout_frozen_cnt", cnt1, 32'd5);

    // A WDEN = 1 write while already enabled has no effect
    wr(2'd0, 32'd1);
    check("reenable_irq",   {31'd0, irq1}, 32'd1);
    check("reenable_state", {30'd0, st1},  32'd2);

    // A WDLIVE write with bit 0 = 0 is not a kick
    wr(2'd1, 32'd0);
    check("nokick_irq", {31'd0, irq1}, 32'd1);

    // Kick in TIMEOUT, then the interrupt rises again 6 edges later
    wr(2'd1, 32'd1);
    check("tkick_irq",   {31'd0, irq1}, 32'd0);
    check("tkick_state", {30'd0, st1},  32'd1);
    check("tkick_cnt",   cnt1,          32'd0);
    for (int k = 0; k < 5; k++) step();
    check("tkick_k5_irq", {31'd0, irq1}, 32'd0);
    check("tkick_k5_cnt", cnt1,          32'd5);
    step();
    check("tkick_k6_irq", {31'd0, irq1}, 32'd1);

    // Kick in COUNT at cnt = 3, in the same cycle as a tick: cnt goes to 0, not 4
    wr(2'd1, 32'd1);
    step(); step(); step();
    check("pre_kick_cnt", cnt1, 32'd3);
    wr(2'd1, 32'd1);
    check("ckick_cnt",   cnt1,         32'd0);
    check("ckick_state", {30'd0, st1}, 32'd1);
    for (int k = 0; k < 5; k++) step();
    check("ckick_k5_irq", {31'd0, irq1}, 32'd0);
    step();
    check("ckick_k6_irq", {31'd0, irq1}, 32'd1);

    // Disable in TIMEOUT
    wr(2'd0, 32'd0);
    check("dis_irq",   {31'd0, irq1}, 32'd0);
    check("dis_state", {30'd0, st1},  32'd0);
    check("dis_cnt",   cnt1,          32'd0);

    // A kick in IDLE is ignored
    wr(2'd1, 32'd1);
    step(); step(); step();
    check("idle_kick_state", {30'd0, st1}, 32'd0);
    check("idle_kick_cnt",   cnt1,         32'd0);

    // Shrink WTOCNT: the write lands at the edge where cnt becomes 4
    wr(2'd0, 32'd1);
    step();
    check("shr_e1_state", {30'd0, st1}, 32'd1);
    step(); step(); step();
    check("shr_cnt3", cnt1, 32'd3);
    wr(2'd2, 32'd2);
    check("shr_cnt4", cnt1,          32'd4);
    check("shr_irq0", {31'd0, irq1}, 32'd0);
    step();
    check("shr_irq1",  {31'd0, irq1}, 32'd1);
    check("shr_state", {30'd0, st1},  32'd2);
    check("shr_frozen", cnt1,         32'd4);
    step();
    check("shr_frozen2", cnt1, 32'd4);

    // Reset mid-count at cnt = 3, applied between edges
    wr(2'd2, 32'd5);
    wr(2'd1, 32'd1);
    step(); step(); step();
    check("mid_cnt3", cnt1, 32'd3);
    #2 rst = 1'b0;
    #1;
    check("async_rst_irq",   {31'd0, irq1}, 32'd0);
    check("async_rst_cnt",   cnt1,          32'd0);
    check("async_rst_state", {30'd0, st1},  32'd0);
    step();
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("post_rst_idle", {30'd0, st1}, 32'd0);
    end

    // WTOCNT reset to 0: enable alone times out at E2
    wr(2'd0, 32'd1);
    step();
    check("w0_e1_state", {30'd0, st1},  32'd1);
    check("w0_e1_irq",   {31'd0, irq1}, 32'd0);
    step();
    check("w0_e2_irq", {31'd0, irq1}, 32'd1);
    check("w0_e2_cnt", cnt1,          32'd0);

    // Reset in TIMEOUT drops the interrupt without a clock edge
    #2 rst = 1'b0;
    #1;
    check("tout_rst_irq",   {31'd0, irq1}, 32'd0);
    check("tout_rst_state", {30'd0, st1},  32'd0);
    step();
    rst = 1'b1;
    step();

    // Prescaler on u4: WTOCNT = 2, interrupt rises at E13
    wr(2'd2, 32'd2);
    wr(2'd0, 32'd1);
    step();
    check("p4_e1_state", {30'd0, st4}, 32'd1);
    check("p4_e1_cnt",   cnt4,         32'd0);
    for (int i = 1; i <= 12; i++) begin
      step();
      check("p4_cnt", cnt4,          (i < 12) ? 32'(i / 4) : 32'd2);
      check("p4_irq", {31'd0, irq4}, (i == 12) ? 32'd1 : 32'd0);
    end
    check("p4_state", {30'd0, st4}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
